free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 125 ++++++++++++
 1 files changed

// File: rtl/free_list.sv
// free_list: circular FIFO of free block indices.
// After reset, an INIT sweep writes index k into slot k, one per cycle, and
// then the block enters RUN with every block free. In RUN, allocations pop the
// FIFO head and return it one cycle later as a registered grant. Frees push
// an index at the tail. Malformed or overflowing frees are dropped and set a
// sticky error flag.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   alloc_req_i         : level-held allocation request
//   alloc_gnt_o         : one-cycle grant pulse
//   alloc_block_idx_o   : granted index; holds its last value between grants
//   free_req_i          : one-cycle free pulse
//   free_block_idx_i    : index being returned
//   ready_o             : initialisation complete (state is RUN)
//   empty_o             : no free blocks (forced 0 during INIT)
//   free_cnt_o          : number of free blocks
//   err_o               : sticky protocol error
module free_list #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_BLOCKS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [ADDR_W-1:0] alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i,
  output logic              ready_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   free_cnt_o,
  output logic              err_o
);

  localparam int unsigned       IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W:0]   FULL  = (ADDR_W + 1)'(NUM_BLOCKS);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mem [NUM_BLOCKS];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] init_cnt;

  logic bad_idx;
  logic full;
  logic do_pop;
  logic do_push;
  logic mark_err;

  always_comb begin
    bad_idx  = ({1'b0, free_block_idx_i} >= FULL);
    full     = (free_cnt_o == FULL);
    do_pop   = (state == RUN) && alloc_req_i && (free_cnt_o != '0);
    do_push  = (state == RUN) && free_req_i && !bad_idx && !full;
    // Any free that is not accepted counts as a protocol error, including
    // frees that arrive before initialisation completes.
    mark_err = free_req_i && ((state == INIT) || bad_idx || full);
  end

  assign empty_o = (state == RUN) && (free_cnt_o == '0);

  // A pop and a push never hit the same slot: equal pointers mean the list
  // is either empty (no pop) or full (push dropped).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[init_cnt[IDX_W-1:0]] <= init_cnt;
      else if (do_push)
        mem[wr_ptr[IDX_W-1:0]] <= free_block_idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INIT;
      alloc_gnt_o       <= 1'b0;
      alloc_block_idx_o <= '0;
      ready_o           <= 1'b0;
      free_cnt_o        <= '0;
      err_o             <= 1'b0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      init_cnt          <= '0;
    end else begin
      alloc_gnt_o <= 1'b0;
      if (mark_err)
        err_o <= 1'b1;

      case (state)
        INIT: begin
          if (init_cnt == LAST) begin
            state      <= RUN;
            ready_o    <= 1'b1;
            free_cnt_o <= FULL;
            init_cnt   <= '0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end

        RUN: begin
          if (do_pop) begin
            alloc_gnt_o       <= 1'b1;
            alloc_block_idx_o <= mem[rd_ptr[IDX_W-1:0]];
            rd_ptr            <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
          end
          if (do_push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

          if (do_pop && !do_push)
            free_cnt_o <= free_cnt_o - 1'b1;
          else if (do_push && !do_pop)
            free_cnt_o <= free_cnt_o + 1'b1;
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule
